// File: rtl/rgb_filter_sequencer_pkg.sv
// Shared types for the RGB filter sequencer: filter modes, sweep channels
// and the cyclic advance helpers used by the mode FSM and sweep counters.
package rgb_ctrl_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    MANUAL = 2'd1,
    SWEEP  = 2'd2
  } filter_mode_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  localparam int MODE_COUNT = 3;
  localparam logic [1:0] LAST_MODE = 2'(MODE_COUNT - 1);

  function automatic filter_mode_e next_mode(input filter_mode_e m);
    if (m == filter_mode_e'(LAST_MODE)) begin
      return BYPASS;
    end
    return filter_mode_e'(m + 2'd1);
  endfunction

  function automatic channel_e next_channel(input channel_e c);
    case (c)
      CH_R:    return CH_G;
      CH_G:    return CH_B;
      default: return CH_R;
    endcase
  endfunction

endpackage

// File: rtl/rgb_filter_sequencer_if.sv
// Control bundle between the board inputs, the sequencer and the RGB filter.
// slave is the sequencer's view; master is the driver/observer view.
interface rgb_filter_sequencer_if;

  logic        frame_tick;
  logic        btn_mode;
  logic [2:0]  sw_en;
  logic [11:0] sw_val;
  logic        r_sw_mode;
  logic        g_sw_mode;
  logic        b_sw_mode;
  logic [3:0]  r_sw;
  logic [3:0]  g_sw;
  logic [3:0]  b_sw;
  logic [1:0]  mode;

  modport master (
    output frame_tick, btn_mode, sw_en, sw_val,
    input  r_sw_mode, g_sw_mode, b_sw_mode, r_sw, g_sw, b_sw, mode
  );

  modport slave (
    input  frame_tick, btn_mode, sw_en, sw_val,
    output r_sw_mode, g_sw_mode, b_sw_mode, r_sw, g_sw, b_sw, mode
  );

endinterface

// File: rtl/rgb_filter_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// single-cycle pulse on each debounced press.
module btn_debounce #(
  parameter int DB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // The stable level flips only after DB_CYCLES consecutive differing samples;
  // any sample matching the stable level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_filter_sequencer.sv
// Frame-synchronous controller for the RGB override filter: button-driven mode
// selection, manual switch overrides and an automatic colour sweep.
module rgb_filter_sequencer
  import rgb_ctrl_pkg::*;
#(
  parameter int DB_CYCLES       = 250000,
  parameter int FRAMES_PER_STEP = 30
) (
  input logic                  clk,
  input logic                  reset,
  rgb_filter_sequencer_if.slave bus
);

  localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FRAMES_PER_STEP - 1);

  logic           press;
  logic [2:0]     sw_en_s1;
  logic [2:0]     sw_en_s2;
  logic [11:0]    sw_val_s1;
  logic [11:0]    sw_val_s2;

  filter_mode_e   mode_q;
  filter_mode_e   pending_q;
  logic [3:0]     level_q;
  channel_e       chan_q;
  logic [FCW-1:0] frame_cnt_q;

  logic [3:0]     nxt_level;
  channel_e       nxt_chan;
  logic [FCW-1:0] nxt_cnt;

  logic           r_mode_q;
  logic           g_mode_q;
  logic           b_mode_q;
  logic [3:0]     r_val_q;
  logic [3:0]     g_val_q;
  logic [3:0]     b_val_q;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_mode),
    .press (press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_en_s1  <= '0;
      sw_en_s2  <= '0;
      sw_val_s1 <= '0;
      sw_val_s2 <= '0;
    end else begin
      sw_en_s1  <= bus.sw_en;
      sw_en_s2  <= sw_en_s1;
      sw_val_s1 <= bus.sw_val;
      sw_val_s2 <= sw_val_s1;
    end
  end

  // Sweep position for the next tick; a tick that enters SWEEP restarts at R/0.
  always_comb begin
    nxt_level = level_q;
    nxt_chan  = chan_q;
    nxt_cnt   = frame_cnt_q;
    if (mode_q != SWEEP) begin
      nxt_level = 4'd0;
      nxt_chan  = CH_R;
      nxt_cnt   = '0;
    end else if (frame_cnt_q == FCNT_LAST) begin
      nxt_cnt   = '0;
      nxt_level = level_q + 4'd1;
      if (level_q == 4'hF) begin
        nxt_chan = next_channel(chan_q);
      end
    end else begin
      nxt_cnt = frame_cnt_q + 1'b1;
    end
  end

  // Presses only move pending_q; everything visible changes on frame_tick, so a
  // press in the tick cycle lands in pending_q after the tick has sampled it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= BYPASS;
      pending_q   <= BYPASS;
      level_q     <= 4'd0;
      chan_q      <= CH_R;
      frame_cnt_q <= '0;
      r_mode_q    <= 1'b0;
      g_mode_q    <= 1'b0;
      b_mode_q    <= 1'b0;
      r_val_q     <= 4'd0;
      g_val_q     <= 4'd0;
      b_val_q     <= 4'd0;
    end else begin
      if (press) begin
        pending_q <= next_mode(pending_q);
      end
      if (bus.frame_tick) begin
        mode_q <= pending_q;
        case (pending_q)
          MANUAL: begin
            r_mode_q <= sw_en_s2[2];
            g_mode_q <= sw_en_s2[1];
            b_mode_q <= sw_en_s2[0];
            r_val_q  <= sw_val_s2[11:8];
            g_val_q  <= sw_val_s2[7:4];
            b_val_q  <= sw_val_s2[3:0];
          end
          SWEEP: begin
            level_q     <= nxt_level;
            chan_q      <= nxt_chan;
            frame_cnt_q <= nxt_cnt;
            r_mode_q    <= 1'b1;
            g_mode_q    <= 1'b1;
            b_mode_q    <= 1'b1;
            r_val_q     <= (nxt_chan == CH_R) ? nxt_level : 4'd0;
            g_val_q     <= (nxt_chan == CH_G) ? nxt_level : 4'd0;
            b_val_q     <= (nxt_chan == CH_B) ? nxt_level : 4'd0;
          end
          default: begin
            r_mode_q <= 1'b0;
            g_mode_q <= 1'b0;
            b_mode_q <= 1'b0;
            r_val_q  <= 4'd0;
            g_val_q  <= 4'd0;
            b_val_q  <= 4'd0;
          end
        endcase
      end
    end
  end

  assign bus.r_sw_mode = r_mode_q;
  assign bus.g_sw_mode = g_mode_q;
  assign bus.b_sw_mode = b_mode_q;
  assign bus.r_sw      = r_val_q;
  assign bus.g_sw      = g_val_q;
  assign bus.b_sw      = b_val_q;
  assign bus.mode      = mode_q;

endmodule
